// File: rtl/spike_pkg.sv
// spike_pkg: shared types, constants and helpers for the spike output collector.
package spike_pkg;

  // Width of the saturating lost-spike counter.
  localparam int DROP_W = 16;

  // Geometry of the default build (4 columns, 16-bit timestamps).
  localparam int DEFAULT_ADDR_W = 2;
  localparam int DEFAULT_TS_W   = 16;

  // Column address width; a single column still needs one address bit.
  function automatic int addr_width(input int num_cols);
    return (num_cols > 1) ? $clog2(num_cols) : 1;
  endfunction

  // One queued spike: source column and capture time (default geometry).
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_TS_W-1:0]   timestamp;
  } spike_entry_t;

endpackage

// File: rtl/spike_output_collector_if.sv
// spike_output_collector_if: output word stream (valid/ready) plus drop counter.
interface spike_output_collector_if
  import spike_pkg::*;
#(
  parameter int ADDR_W   = 2,
  parameter int TS_WIDTH = 16
);
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_addr;
  logic [TS_WIDTH-1:0] out_timestamp;
  logic [DROP_W-1:0]   drop_count;

  // Collector side produces words; consumer side accepts them.
  modport master (output out_valid, output out_addr, output out_timestamp,
                  output drop_count, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_timestamp,
                  input drop_count, output out_ready);
endinterface

// File: rtl/spike_fifo.sv
// spike_fifo: first-word-fall-through FIFO of spike entries. A push while
// full is accepted when a pop happens in the same cycle.
module spike_fifo
  import spike_pkg::*;
#(
  parameter type entry_t = spike_entry_t,
  parameter int  DEPTH   = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CW'(1);
    end
  end
endmodule

// File: rtl/spike_output_collector.sv
// spike_output_collector: per-column pending flags, round-robin arbiter into
// an output FIFO, saturating drop counter.
// Optional feature macro SPIKE_TIMESTAMP_EN: builds the free-running timestamp
// counter and per-column capture registers; otherwise only addresses are queued
// and out_timestamp is tied to zero.
module spike_output_collector
  import spike_pkg::*;
#(
  parameter int NUM_COLS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_COLS-1:0]      col_spike,
  spike_output_collector_if.master out_if
);
  localparam int AW = addr_width(NUM_COLS);

`ifdef SPIKE_TIMESTAMP_EN
  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [TS_WIDTH-1:0] timestamp;
  } entry_t;
`else
  typedef struct packed {
    logic [AW-1:0] addr;
  } entry_t;
`endif

  logic [NUM_COLS-1:0] pending_reg;
  logic [AW-1:0]       rr_ptr_reg;
  logic [DROP_W-1:0]   drop_count_reg;
  logic [NUM_COLS-1:0] grant_vec;
  logic [NUM_COLS-1:0] accept_vec;
  logic [NUM_COLS-1:0] drop_vec;
  logic                grant_valid;
  logic [AW-1:0]       grant_idx;
  logic [AW-1:0]       scan_idx;
  logic [AW:0]         drop_n;
  logic [DROP_W:0]     drop_sum;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                stall;
  entry_t              push_entry;
  entry_t              pop_entry;

`ifdef SPIKE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_reg;
  logic [TS_WIDTH-1:0] ts_latch_reg [NUM_COLS];

  // Free-running capture time, wraps from all-ones to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + TS_WIDTH'(1);
  end

  // Capture time only for accepted pulses; a dropped pulse keeps the older stamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COLS; i++) ts_latch_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COLS; i++)
        if (accept_vec[i]) ts_latch_reg[i] <= ts_reg;
    end
  end
`endif

  // A pop frees a slot in the same cycle, so only full-and-not-popping stalls.
  assign fifo_pop = !fifo_empty && out_if.out_ready;
  assign stall    = fifo_full && !fifo_pop;

  // Round-robin search starting at the column after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr_reg;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!stall && !grant_valid && pending_reg[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == AW'(NUM_COLS - 1)) ? '0 : scan_idx + AW'(1);
    end
  end

  // Per column: a pulse is taken if the slot is free or being granted now.
  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    assign grant_vec[gi]  = grant_valid && (grant_idx == AW'(gi));
    assign accept_vec[gi] = col_spike[gi] && (!pending_reg[gi] || grant_vec[gi]);
    assign drop_vec[gi]   = col_spike[gi] && pending_reg[gi] && !grant_vec[gi];
  end

  // Count columns losing a pulse this cycle and form the saturating sum.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_COLS; i++) drop_n = drop_n + (AW + 1)'(drop_vec[i]);
    drop_sum = {1'b0, drop_count_reg} + (DROP_W + 1)'(drop_n);
  end

  // Pending flags: grant clears, accepted pulse sets (set wins over clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= (pending_reg & ~grant_vec) | accept_vec;
  end

  // Arbiter pointer moves past each granted column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            rr_ptr_reg <= '0;
    else if (grant_valid) rr_ptr_reg <= (grant_idx == AW'(NUM_COLS - 1)) ? '0 : grant_idx + AW'(1);
  end

  // Lost-spike counter sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_count_reg <= '0;
    else       drop_count_reg <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Entry pushed on grant: column plus its captured time.
  always_comb begin
    push_entry      = '0;
    push_entry.addr = grant_idx;
`ifdef SPIKE_TIMESTAMP_EN
    push_entry.timestamp = ts_latch_reg[grant_idx];
`endif
  end

  spike_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant_valid),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs read zero whenever nothing is queued (including right after reset).
  assign out_if.out_valid  = !fifo_empty;
  assign out_if.out_addr   = fifo_empty ? '0 : pop_entry.addr;
  assign out_if.drop_count = drop_count_reg;
`ifdef SPIKE_TIMESTAMP_EN
  assign out_if.out_timestamp = fifo_empty ? '0 : pop_entry.timestamp;
`else
  assign out_if.out_timestamp = {TS_WIDTH{1'b0}};
`endif
endmodule

// File: doc/spike_output_collector.md
SPIKE_OUTPUT_COLLECTOR -- requirements
Module: spike_output_collector

Interface
REQ-001 SHALL have parameter NUM_COLS, default 4: number of neuron columns feeding the block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2: output FIFO entries.
REQ-003 SHALL have parameter TS_WIDTH, default 16: timestamp width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port col_spike, input, NUM_COLS: per-column spike, one-cycle pulse per event.
REQ-007 SHALL have port out_valid, output, 1: output word available.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts word when high with out_valid.
REQ-009 SHALL have port out_addr, output, $clog2(NUM_COLS) (min 1): source column of the word.
REQ-010 SHALL have port out_timestamp, output, TS_WIDTH: capture time of the spike.
REQ-011 SHALL have port drop_count, output, 16: saturating count of lost spikes.

Function
REQ-012 Free-running TS_WIDTH counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-013 Per column: a col_spike pulse SHALL set a pending bit and latch the counter value of the pulse cycle.
REQ-014 A pulse on a column whose pending bit is set and not granted that cycle SHALL be dropped; drop_count SHALL increment by 1 (by number of such columns in the cycle), saturating at 16'hFFFF.
REQ-015 Pulse and grant on the same column in the same cycle: SHALL clear-then-set, i.e. pending stays 1 with the new timestamp; no drop.
REQ-016 Round-robin arbiter SHALL grant at most one pending column per cycle, only when the FIFO is not full, starting search at the column after the last grant (column 0 after reset).
REQ-017 Grant SHALL push {column, latched timestamp} into the FIFO and clear that pending bit at the same edge.
REQ-018 FIFO SHALL be first-word-fall-through; out_valid = FIFO not empty; pop on out_valid && out_ready.
REQ-019 Latency: pulse in cycle N, empty FIFO, no contention -> out_valid high in cycle N+2 with matching out_addr/out_timestamp.
REQ-020 Simultaneous push and pop SHALL be allowed, including when full (pop frees the slot in the same cycle; the arbiter SHALL use full-and-not-popping as the stall condition).
REQ-021 out_addr/out_timestamp SHALL hold stable while out_valid && !out_ready.
REQ-022 FIFO full: pending bits SHALL hold; no spike lost except per REQ-014.

Reset
REQ-023 On reset assertion, asynchronously: pending bits 0, FIFO empty, out_valid 0, out_addr 0, out_timestamp 0, drop_count 0, timestamp counter 0, round-robin pointer to column 0.
REQ-024 Reset mid-operation SHALL discard all pending and queued spikes; first cycle after deassertion SHALL accept new pulses.

Configuration
REQ-025 Macro SPIKE_TIMESTAMP_EN defined: timestamp counter and per-column latches built; out_timestamp per REQ-013.
REQ-026 Macro SPIKE_TIMESTAMP_EN undefined: no counter, no latches, FIFO stores address only, out_timestamp tied 0; all other behaviour unchanged.

Structure
REQ-027 Package spike_pkg SHALL hold the FIFO entry struct typedef (addr, timestamp), the address-width function, and the drop counter width constant 16.
REQ-028 FIFO SHALL be a separate sub-module spike_fifo (parameterised entry type/width, depth), with push/pop/full/empty.

Verification
REQ-029 Single pulse col 2 at counter 5, out_ready=1 -> out_valid 2 cycles later, out_addr=2, out_timestamp=5, then out_valid 0.
REQ-030 Pulses on cols 0..3 same cycle, out_ready=1 -> four words in order 0,1,2,3 on consecutive cycles, identical timestamps.
REQ-031 out_ready=0, 12 distinct-column pulse bursts (4 cols) -> FIFO fills to 8, 4 pending held, further repeats on held columns increment drop_count; release ready -> 12 words, no reorder within a column.
REQ-032 Col 1 pulsed twice 1 cycle apart with FIFO full -> drop_count=1; with FIFO empty and grant coinciding -> drop_count=0, two words.
REQ-033 Reset asserted with 3 words queued and 2 pending -> all outputs 0 immediately, no words emitted after release.
REQ-034 Counter near wrap (all-ones) plus pulse next cycle -> out_timestamp=0; build without SPIKE_TIMESTAMP_EN -> out_timestamp always 0, addresses identical.
